// File: rtl/mx_dot_acc_if.sv
// Handshake bundle between the element multiplier and the block accumulator.
// slave: i_prd/i_valid/i_clear/i_ready in; o_ready/o_sum/o_valid/o_count out.
interface mx_dot_acc_if #(
  parameter int prd_width = 18,
  parameter int cnt_width = 5,
  parameter int acc_width = prd_width + cnt_width
);
  logic [prd_width-1:0] i_prd;
  logic                 i_valid;
  logic                 o_ready;
  logic                 i_clear;
  logic [acc_width-1:0] o_sum;
  logic                 o_valid;
  logic                 i_ready;
  logic [cnt_width-1:0] o_count;

  modport slave (
    input  i_prd, i_valid, i_clear, i_ready,
    output o_ready, o_sum, o_valid, o_count
  );

  modport master (
    output i_prd, i_valid, i_clear, i_ready,
    input  o_ready, o_sum, o_valid, o_count
  );
endinterface

// File: rtl/mx_dot_acc.sv
// Exact block dot-product accumulator: sums block_size signed products.
// Ports: clk, rst (sync, active high), bus (mx_dot_acc_if.slave).
module mx_dot_acc #(
  parameter int exp_width  = 2,
  parameter int man_width  = 3,
  parameter int prd_width  = 2*((1<<exp_width)+man_width+2),
  parameter int block_size = 32,
  parameter int cnt_width  = $clog2(block_size),
  parameter int acc_width  = prd_width + cnt_width
) (
  input  logic          clk,
  input  logic          rst,
  mx_dot_acc_if.slave   bus
);

  logic signed [acc_width-1:0] acc_q, acc_d;
  logic signed [acc_width-1:0] sum_q, sum_d;
  logic [cnt_width-1:0]        cnt_q, cnt_d;
  logic                        vld_q, vld_d;

  logic                        last;
  logic                        rdy;
  logic                        in_beat;
  logic                        out_beat;
  logic signed [acc_width-1:0] prd_ext;
  logic signed [acc_width-1:0] acc_nxt;

  assign last     = (cnt_q == cnt_width'(block_size-1));
  // Only the completing beat needs the output register to be free.
  assign rdy      = !(last && vld_q && !bus.i_ready);
  assign in_beat  = bus.i_valid && rdy;
  assign out_beat = vld_q && bus.i_ready;
  assign prd_ext  = acc_width'($signed(bus.i_prd));
  assign acc_nxt  = acc_q + prd_ext;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    sum_d = sum_q;
    vld_d = vld_q;
    if (out_beat) vld_d = 1'b0;
    if (bus.i_clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (in_beat) begin
      if (last) begin
        // A completing beat refills the slot even if it drains now.
        sum_d = acc_nxt;
        vld_d = 1'b1;
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = acc_nxt;
        cnt_d = cnt_q + cnt_width'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      sum_q <= '0;
      vld_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      vld_q <= vld_d;
    end
  end

  assign bus.o_ready = rdy;
  assign bus.o_sum   = sum_q;
  assign bus.o_valid = vld_q;
  assign bus.o_count = cnt_q;

endmodule
